// File: rtl/alu_issue_ctrl.sv
// Round-robin issue controller for the shared ALU: grants one of two requesters,
// holds operands while the ALU is busy, and returns the tagged result.
module alu_issue_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        i_clk_n,
    input  logic        i_rst,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [31:0] i_req0_a,
    input  logic [31:0] i_req0_b,
    input  logic [2:0]  i_req0_funct3,
    input  logic [6:0]  i_req0_funct7,
    input  logic        i_req0_imm,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [31:0] i_req1_a,
    input  logic [31:0] i_req1_b,
    input  logic [2:0]  i_req1_funct3,
    input  logic [6:0]  i_req1_funct7,
    input  logic        i_req1_imm,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [2:0]  o_alu_funct3,
    output logic [6:0]  o_alu_funct7,
    output logic        o_alu_imm,
    output logic        o_alu_en,
    input  logic        i_alu_busy,
    input  logic [31:0] i_alu_out,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_id,
    output logic        o_rsp_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]        alu_f3_q, alu_f3_d;
    logic [6:0]        alu_f7_q, alu_f7_d;
    logic              alu_imm_q, alu_imm_d;
    logic              alu_en_q, alu_en_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_id_q, rsp_id_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              grant_vld_s, grant_s;

    // Arbitration: a lone requester wins; on contention rr_q picks the winner.
    always_comb begin
        grant_vld_s = i_req0_valid | i_req1_valid;
        if (i_req0_valid && i_req1_valid) begin
            grant_s = rr_q;
        end else if (i_req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign o_req0_ready = (state_q == S_IDLE) && grant_vld_s && (grant_s == 1'b0);
    assign o_req1_ready = (state_q == S_IDLE) && grant_vld_s && (grant_s == 1'b1);

    // Next-state and datapath load logic for the issue sequencer.
    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_f3_d      = alu_f3_q;
        alu_f7_d      = alu_f7_q;
        alu_imm_d     = alu_imm_q;
        alu_en_d      = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_id_d      = rsp_id_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld_s) begin
                    state_d   = S_ISSUE;
                    alu_en_d  = 1'b1;
                    rr_d      = ~grant_s;
                    rsp_id_d  = grant_s;
                    if (grant_s) begin
                        alu_a_d   = i_req1_a;
                        alu_b_d   = i_req1_b;
                        alu_f3_d  = i_req1_funct3;
                        alu_f7_d  = i_req1_funct7;
                        alu_imm_d = i_req1_imm;
                    end else begin
                        alu_a_d   = i_req0_a;
                        alu_b_d   = i_req0_b;
                        alu_f3_d  = i_req0_funct3;
                        alu_f7_d  = i_req0_funct7;
                        alu_imm_d = i_req0_imm;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (!i_alu_busy) begin
                    state_d       = S_DONE;
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = i_alu_out;
                    rsp_timeout_d = 1'b0;
                end else begin
                    state_d  = S_WAIT;
                    cnt_d    = ONE_C;
                    alu_en_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (!i_alu_busy) begin
                    state_d       = S_DONE;
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = i_alu_out;
                    rsp_timeout_d = 1'b0;
                end else if (cnt_q == TMO_C) begin
                    // Abort: report a zero result flagged as timed out.
                    state_d       = S_DONE;
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = 32'd0;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d    = cnt_q + ONE_C;
                    alu_en_d = 1'b1;
                end
            end
            S_DONE: begin
                if (i_rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk_n) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            rr_q          <= 1'b0;
            cnt_q         <= '0;
            alu_a_q       <= 32'd0;
            alu_b_q       <= 32'd0;
            alu_f3_q      <= 3'd0;
            alu_f7_q      <= 7'd0;
            alu_imm_q     <= 1'b0;
            alu_en_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 32'd0;
            rsp_id_q      <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_f3_q      <= alu_f3_d;
            alu_f7_q      <= alu_f7_d;
            alu_imm_q     <= alu_imm_d;
            alu_en_q      <= alu_en_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_id_q      <= rsp_id_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign o_alu_a       = alu_a_q;
    assign o_alu_b       = alu_b_q;
    assign o_alu_funct3  = alu_f3_q;
    assign o_alu_funct7  = alu_f7_q;
    assign o_alu_imm     = alu_imm_q;
    assign o_alu_en      = alu_en_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_data    = rsp_data_q;
    assign o_rsp_id      = rsp_id_q;
    assign o_rsp_timeout = rsp_timeout_q;

endmodule
